// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder: word-organised memory behind a registered address phase,
// with a fixed number of wait states per OKAY transfer and a two-cycle ERROR response.
module ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp
);

    localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
    localparam logic [1:0] WS_LOAD = 2'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                  state, state_nxt;
    logic [1:0]              cnt, cnt_nxt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic [2:0]              size_q;
    logic [31:0]             mem [DEPTH];

    logic open, accept, illegal;
    logic [3:0] lanes;
    logic unused;

    assign unused = ^{haddr[31:ADDR_WIDTH], htrans[0]};

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
        case (size)
            3'd0:    lane_mask = 4'b0001 << a;
            3'd1:    lane_mask = a[1] ? 4'b1100 : 4'b0011;
            3'd2:    lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    // New address phases are only taken in states that drive hreadyout high
    assign open    = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
    assign accept  = open && hsel && hready && htrans[1];
    assign illegal = (hsize > 3'd2)
                   || ((hsize == 3'd1) && haddr[0])
                   || ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
    assign lanes   = lane_mask(size_q, addr_q[1:0]);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hreadyout = 1'b1;
        hresp     = 1'b0;
        case (state)
            S_IDLE, S_DATA, S_ERR2: begin
                hresp     = (state == S_ERR2);
                state_nxt = S_IDLE;
                if (accept) begin
                    if (illegal) begin
                        state_nxt = S_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        state_nxt = S_DATA;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = WS_LOAD;
                    end
                end
            end
            S_WAIT: begin
                hreadyout = 1'b0;
                if (cnt == 2'd0) state_nxt = S_DATA;
                else             cnt_nxt   = cnt - 2'd1;
            end
            S_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
                state_nxt = S_ERR2;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= 2'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                addr_q  <= haddr[ADDR_WIDTH-1:0];
                write_q <= hwrite;
                size_q  <= hsize;
            end
        end
    end

    // A reset on the completing edge drops the pending write
    always_ff @(posedge clk) begin
        if (reset && (state == S_DATA) && write_q) begin
            for (int k = 0; k < 4; k++) begin
                if (lanes[k]) mem[addr_q[ADDR_WIDTH-1:2]][8*k +: 8] <= hwdata[8*k +: 8];
            end
        end
    end

    assign hrdata = ((state == S_DATA) && !write_q) ? mem[addr_q[ADDR_WIDTH-1:2]] : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: three responders (0, 2 and 3 wait states) behind a small decoder
// and HREADY mux, driven one at a time through a shared master.
module tb_ahb_sram_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [1:0]  dsel;

    logic [2:0]  ro, rsp;
    logic [31:0] rd0, rd1, rd2;
    logic        hro, hrsp, hready;
    logic [31:0] hrd;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always_comb begin
        hro  = ro[0];
        hrsp = rsp[0];
        hrd  = rd0;
        case (dsel)
            2'd1: begin hro = ro[1]; hrsp = rsp[1]; hrd = rd1; end
            2'd2: begin hro = ro[2]; hrsp = rsp[2]; hrd = rd2; end
            default: ;
        endcase
    end
    assign hready = hro;

    ahb_sram_slave #(.ADDR_WIDTH(12), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(reset), .hsel(hsel && (dsel == 2'd0)), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
        .hready(hready), .hrdata(rd0), .hreadyout(ro[0]), .hresp(rsp[0]));

    ahb_sram_slave #(.ADDR_WIDTH(12), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .reset(reset), .hsel(hsel && (dsel == 2'd1)), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
        .hready(hready), .hrdata(rd1), .hreadyout(ro[1]), .hresp(rsp[1]));

    ahb_sram_slave #(.ADDR_WIDTH(12), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .reset(reset), .hsel(hsel && (dsel == 2'd2)), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
        .hready(hready), .hrdata(rd2), .hreadyout(ro[2]), .hresp(rsp[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transfer; reports wait cycles, first/last hresp and completing hrdata
    task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rdat,
                        output int waits, output logic resp_first, output logic resp_last);
        haddr = a; hwrite = w; hsize = sz; htrans = 2'b10; hsel = 1'b1;
        @(posedge clk); #1;
        htrans = 2'b00; hsel = 1'b0; hwdata = wd;
        waits = 0; rdat = 'x; resp_first = 1'bx; resp_last = 1'bx;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) resp_first = hrsp;
            resp_last = hrsp;
            if (hro) begin
                rdat = hrd;
                break;
            end
            waits++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    logic [31:0] rdat;
    int          waits;
    logic        rf, rl;

    initial begin
        reset = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
        hsize = 3'd2; hwdata = '0; dsel = 2'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_ready", {29'd0, ro}, 32'h7);
        chk("rst_resp",  {29'd0, rsp}, 32'h0);
        chk("rst_rdata", rd0 | rd1 | rd2, 32'h0);

        // back-to-back write then read, no wait states
        @(posedge clk); #1;
        haddr = 32'h010; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10; hsel = 1'b1;
        @(posedge clk); #1;
        hwdata = 32'hDEADBEEF; hwrite = 1'b0; htrans = 2'b10;
        @(negedge clk);
        chk("b2b_wr_ready", {31'd0, hro}, 32'h1);
        chk("b2b_wr_rdata", hrd, 32'h0);
        @(posedge clk); #1;
        htrans = 2'b00; hsel = 1'b0;
        @(negedge clk);
        chk("b2b_rd_ready", {31'd0, hro}, 32'h1);
        chk("b2b_rd_data", hrd, 32'hDEADBEEF);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b_after_rdata", hrd, 32'h0);

        // byte and halfword lanes
        xfer(32'h020, 1'b1, 3'd2, 32'h11223344, rdat, waits, rf, rl);
        xfer(32'h021, 1'b1, 3'd0, 32'h0000AA00, rdat, waits, rf, rl);
        xfer(32'h022, 1'b1, 3'd1, 32'hBBCC0000, rdat, waits, rf, rl);
        xfer(32'h020, 1'b0, 3'd2, 32'h0, rdat, waits, rf, rl);
        chk("lanes_data", rdat, 32'hBBCCAA44);
        chk("lanes_waits", 32'(waits), 32'd0);
        xfer(32'h023, 1'b0, 3'd0, 32'h0, rdat, waits, rf, rl);
        chk("byte_read_full_word", rdat, 32'hBBCCAA44);

        // error responses leave memory untouched
        xfer(32'h030, 1'b1, 3'd2, 32'h55667788, rdat, waits, rf, rl);
        xfer(32'h031, 1'b1, 3'd1, 32'hFFFFFFFF, rdat, waits, rf, rl);
        chk("err_half_waits", 32'(waits), 32'd1);
        chk("err_half_resp1", {31'd0, rf}, 32'h1);
        chk("err_half_resp2", {31'd0, rl}, 32'h1);
        xfer(32'h030, 1'b0, 3'd2, 32'h0, rdat, waits, rf, rl);
        chk("err_half_mem", rdat, 32'h55667788);
        chk("err_half_okay", {31'd0, rl}, 32'h0);
        xfer(32'h030, 1'b1, 3'd3, 32'hFFFFFFFF, rdat, waits, rf, rl);
        chk("err_size3_waits", 32'(waits), 32'd1);
        chk("err_size3_resp", {30'd0, rf, rl}, 32'h3);
        xfer(32'h032, 1'b1, 3'd2, 32'hFFFFFFFF, rdat, waits, rf, rl);
        chk("err_word_misalign", {30'd0, rf, rl}, 32'h3);
        xfer(32'h030, 1'b0, 3'd2, 32'h0, rdat, waits, rf, rl);
        chk("err_size3_mem", rdat, 32'h55667788);

        // IDLE, BUSY and unselected traffic
        haddr = 32'h030; hwrite = 1'b1; hsize = 3'd2; hwdata = 32'h0BADF00D;
        hsel = 1'b1; htrans = 2'b00;
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_resp", {30'd0, hro, hrsp}, 32'h2);
        htrans = 2'b01;
        @(posedge clk); #1;
        @(negedge clk);
        chk("busy_resp", {30'd0, hro, hrsp}, 32'h2);
        hsel = 1'b0; htrans = 2'b10;
        @(posedge clk); #1;
        @(negedge clk);
        chk("unsel_resp", {30'd0, hro, hrsp}, 32'h2);
        @(posedge clk); #1;
        htrans = 2'b00;
        xfer(32'h030, 1'b0, 3'd2, 32'h0, rdat, waits, rf, rl);
        chk("idle_busy_mem", rdat, 32'h55667788);

        // two wait states
        dsel = 2'd1;
        xfer(32'h100, 1'b1, 3'd2, 32'hCAFEF00D, rdat, waits, rf, rl);
        chk("ws2_wr_waits", 32'(waits), 32'd2);
        haddr = 32'h100; hwrite = 1'b0; hsize = 3'd2; htrans = 2'b10; hsel = 1'b1;
        @(posedge clk); #1;
        // an illegal transfer presented while hready is low must be ignored
        haddr = 32'h101; hwrite = 1'b1; hsize = 3'd3;
        @(negedge clk);
        chk("ws2_c1", {hro, hrd}, {1'b0, 32'h0});
        @(posedge clk); #1;
        @(negedge clk);
        chk("ws2_c2", {hro, hrd}, {1'b0, 32'h0});
        @(posedge clk); #1;
        htrans = 2'b00; hsel = 1'b0;
        @(negedge clk);
        chk("ws2_c3", {hro, hrd}, {1'b1, 32'hCAFEF00D});
        @(posedge clk); #1;
        @(negedge clk);
        chk("ws2_held_ignored", {30'd0, hro, hrsp}, 32'h2);

        // reset during the second wait cycle, three wait states
        dsel = 2'd2;
        xfer(32'h040, 1'b1, 3'd2, 32'hA5A5A5A5, rdat, waits, rf, rl);
        chk("ws3_wr_waits", 32'(waits), 32'd3);
        haddr = 32'h040; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10; hsel = 1'b1;
        @(posedge clk); #1;
        htrans = 2'b00; hsel = 1'b0; hwdata = 32'h12345678;
        @(negedge clk);
        chk("ws3_wait1", {31'd0, hro}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("ws3_wait2", {31'd0, hro}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("ws3_rst_out", {hro, hrsp, hrd}, {1'b1, 1'b0, 32'h0});
        xfer(32'h040, 1'b0, 3'd2, 32'h0, rdat, waits, rf, rl);
        chk("ws3_rst_mem", rdat, 32'hA5A5A5A5);
        chk("ws3_rd_waits", 32'(waits), 32'd3);
        dsel = 2'd0;
        xfer(32'h010, 1'b0, 3'd2, 32'h0, rdat, waits, rf, rl);
        chk("mem_survives_reset", rdat, 32'hDEADBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
